// File: rtl/dt_pkg.sv
// Shared types and constants for the distance-transform result-memory path.
package dt_pkg;

  localparam int RES_ADDR_W = 14;
  localparam int RES_DATA_W = 8;

  typedef struct packed {
    logic                  we;
    logic [RES_ADDR_W-1:0] addr;
    logic [RES_DATA_W-1:0] wdata;
  } res_cmd_t;

  typedef enum logic {
    FREE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // (v + 1) mod n, used to advance the round-robin pointer past a requester
  function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/dt_res_arbiter_if.sv
// Requester-side bundle of the result-memory arbiter: commands in, grants and read returns out.
interface dt_res_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = dt_pkg::RES_ADDR_W,
  parameter int DATA_W = dt_pkg::RES_DATA_W
);

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             we;
  logic [NREQ-1:0]             lock;
  logic [NREQ-1:0][ADDR_W-1:0] addr;
  logic [NREQ-1:0][DATA_W-1:0] wdata;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             rvalid;
  logic [DATA_W-1:0]           rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dt_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start wins, one-hot out.
module dt_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dt_res_arbiter.sv
// Single-port result-memory arbiter with lock/hold-timeout and registered memory bus.
// Define DT_ARB_RR_EN for round-robin arbitration in FREE; otherwise fixed priority (lowest index).
module dt_res_arbiter
  import dt_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = RES_ADDR_W,
  parameter int DATA_W   = RES_DATA_W,
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  dt_res_arbiter_if.slave   bus,
  output logic              lock_err,
  output logic              res_wr,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);

  arb_state_t      state, state_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [HW-1:0]   hc, hc_nx;
  logic            lock_err_nx;

  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] gnt;
  logic            acc;
  logic [IW-1:0]   win;
  res_cmd_t        cmd;
  logic            cmd_lock;

  logic [IW-1:0]   rd_tag_p1;
  logic [NREQ-1:0] rvalid_nx;
  logic [NREQ-1:0] vld_p2;

`ifdef DT_ARB_RR_EN
  logic [IW-1:0]   ptr, ptr_nx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return IW'(inc_mod(int'(i), NREQ));
  endfunction

  dt_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .start (ptr),
    .gnt   (pick)
  );
`else
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end
`endif

  // Grant depends only on req, state, owner and pointer; forced low while in reset
  always_comb begin
    gnt = '0;
    if (!reset) begin
      gnt = '0;
    end else if (state == FREE) begin
      gnt = pick;
    end else begin
      gnt[owner] = bus.req[owner];
    end
  end

  assign bus.gnt = gnt;
  assign acc     = |(bus.req & gnt);

  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win = IW'(i);
    end
  end

  always_comb begin
    cmd.we    = bus.we[win];
    cmd.addr  = bus.addr[win];
    cmd.wdata = bus.wdata[win];
    cmd_lock  = bus.lock[win];
  end

  // Ownership state machine: next state, hold counter, sticky error, pointer
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    hc_nx       = hc;
    lock_err_nx = lock_err;
`ifdef DT_ARB_RR_EN
    ptr_nx      = ptr;
`endif
    case (state)
      FREE: begin
        if (acc) begin
          if (cmd_lock) begin
            state_nx = OWNED;
            owner_nx = win;
            hc_nx    = HW'(1);
          end else begin
`ifdef DT_ARB_RR_EN
            ptr_nx = next_idx(win);
`endif
          end
        end
      end
      OWNED: begin
        if (acc && !cmd_lock) begin
          state_nx = FREE;
          hc_nx    = '0;
`ifdef DT_ARB_RR_EN
          ptr_nx   = next_idx(owner);
`endif
        end else if (hc == HW'(HOLD_MAX)) begin
          state_nx    = FREE;
          hc_nx       = '0;
          lock_err_nx = 1'b1;
`ifdef DT_ARB_RR_EN
          ptr_nx      = next_idx(owner);
`endif
        end else begin
          hc_nx = hc + HW'(1);
        end
      end
      default: state_nx = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FREE;
      owner    <= '0;
      hc       <= '0;
      lock_err <= 1'b0;
`ifdef DT_ARB_RR_EN
      ptr      <= '0;
`endif
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      hc       <= hc_nx;
      lock_err <= lock_err_nx;
`ifdef DT_ARB_RR_EN
      ptr      <= ptr_nx;
`endif
    end
  end

  // Stage p1: accepted beat onto the memory bus; read tag remembered for the return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_wr    <= 1'b0;
      res_rd    <= 1'b0;
      res_addr  <= '0;
      res_do    <= '0;
      rd_tag_p1 <= '0;
    end else begin
      res_wr <= acc & cmd.we;
      res_rd <= acc & ~cmd.we;
      if (acc) begin
        res_addr <= cmd.addr;
        if (cmd.we) res_do <= cmd.wdata;
        else        rd_tag_p1 <= win;
      end
    end
  end

  always_comb begin
    rvalid_nx = '0;
    if (res_rd) rvalid_nx[rd_tag_p1] = 1'b1;
  end

  // Stage p2: read return, data passed straight through from the memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p2 <= '0;
    else        vld_p2 <= rvalid_nx;
  end

  assign bus.rvalid = vld_p2;
  assign bus.rdata  = res_di;

endmodule

// File: tb/tb_dt_res_arbiter.sv
// Directed bench for dt_res_arbiter: vector table plus lock, timeout, reset and ordering sequences.
module tb_dt_res_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lock_err;
  logic        res_wr, res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [7:0]  res_di = '0;
  logic [7:0]  mem [0:16383];

  int errors = 0;
  int checks = 0;

  dt_res_arbiter_if #(.NREQ(2), .ADDR_W(14), .DATA_W(8)) bus ();

  dt_res_arbiter #(.NREQ(2), .ADDR_W(14), .DATA_W(8), .HOLD_MAX(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .lock_err (lock_err),
    .res_wr   (res_wr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_do   (res_do),
    .res_di   (res_di)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: read data valid the cycle after res_rd
  always @(posedge clk) begin
    if (res_wr) mem[res_addr] <= res_do;
    if (res_rd) res_di <= mem[res_addr];
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [13:0] a0;
    logic [13:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  gnt;
    logic        wr;
    logic        rd;
    logic [13:0] addr;
    logic [7:0]  dout;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [13:0] a0, input logic [13:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    bus.req      = r;
    bus.we       = w;
    bus.lock     = l;
    bus.addr[0]  = a0;
    bus.addr[1]  = a1;
    bus.wdata[0] = d0;
    bus.wdata[1] = d1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cexp [4];
    int         n;
    logic       le_early;

    tbl[0] = '{2'b01, 2'b01, 14'h0081, 14'h0000, 8'h5A, 8'h00, 2'b01, 1'b1, 1'b0, 14'h0081, 8'h5A};
    tbl[1] = '{2'b10, 2'b10, 14'h0000, 14'h1234, 8'h00, 8'hAA, 2'b10, 1'b1, 1'b0, 14'h1234, 8'hAA};
    tbl[2] = '{2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 14'h1234, 8'hAA};
    tbl[3] = '{2'b01, 2'b01, 14'h3FFF, 14'h0000, 8'h3C, 8'h00, 2'b01, 1'b1, 1'b0, 14'h3FFF, 8'h3C};
    tbl[4] = '{2'b10, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 14'h0000, 8'h3C};
    tbl[5] = '{2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 14'h0000, 8'h3C};
    tbl[6] = '{2'b10, 2'b00, 14'h0000, 14'h0081, 8'h00, 8'h77, 2'b10, 1'b0, 1'b1, 14'h0081, 8'h3C};

`ifdef DT_ARB_RR_EN
    cexp[0] = 2'b01; cexp[1] = 2'b10; cexp[2] = 2'b01; cexp[3] = 2'b10;
`else
    cexp[0] = 2'b01; cexp[1] = 2'b01; cexp[2] = 2'b01; cexp[3] = 2'b01;
`endif

    // Reset state with requests pending
    idle();
    repeat (2) @(negedge clk);
    drive(2'b11, 2'b00, 2'b00, 14'h0010, 14'h0020, 8'h00, 8'h00);
    #1;
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_bus", {res_wr, res_rd, res_addr, res_do}, 0);
    chk("rst_rvalid", bus.rvalid, 2'b00);
    chk("rst_lock_err", lock_err, 1'b0);
    @(negedge clk);
    idle();
    reset = 1'b1;

    // Single-beat vectors from the table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].we, 2'b00, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #1;
      chk($sformatf("vec%0d_gnt", i), bus.gnt, tbl[i].gnt);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wr", i), res_wr, tbl[i].wr);
      chk($sformatf("vec%0d_rd", i), res_rd, tbl[i].rd);
      chk($sformatf("vec%0d_addr", i), res_addr, tbl[i].addr);
      chk($sformatf("vec%0d_do", i), res_do, tbl[i].dout);
    end

    // Single read with return timing
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 14'h0081, 14'h0, 8'h0, 8'h0);
    #1;
    chk("rd_gnt", bus.gnt, 2'b01);
    @(posedge clk);
    #1;
    idle();
    chk("rd_strobe", {res_rd, res_wr}, 2'b10);
    chk("rd_addr", res_addr, 14'h0081);
    chk("rd_rvalid_early", bus.rvalid, 2'b00);
    @(posedge clk);
    #1;
    chk("rd_rvalid", bus.rvalid, 2'b01);
    chk("rd_rdata", bus.rdata, 8'h5A);

    // Contention, both requesters held for four beats
    do_reset();
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b00, 14'h0010, 14'h0020, 8'h0, 8'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont%0d_gnt", k), bus.gnt, cexp[k]);
      @(negedge clk);
    end
    idle();

    // Read-modify-write under lock while requester 0 waits
    do_reset();
    @(negedge clk);
    drive(2'b10, 2'b00, 2'b10, 14'h0200, 14'h0100, 8'h0, 8'h0);
    #1;
    chk("rmw_rd_gnt", bus.gnt, 2'b10);
    @(posedge clk);
    #1;
    chk("rmw_rd_strobe", {res_rd, res_wr}, 2'b10);
    chk("rmw_rd_addr", res_addr, 14'h0100);
    @(negedge clk);
    drive(2'b11, 2'b10, 2'b00, 14'h0200, 14'h0100, 8'h0, 8'h05);
    #1;
    chk("rmw_wr_gnt", bus.gnt, 2'b10);
    @(posedge clk);
    #1;
    chk("rmw_wr_strobe", {res_rd, res_wr}, 2'b01);
    chk("rmw_wr_addr", res_addr, 14'h0100);
    chk("rmw_wr_do", res_do, 8'h05);
    chk("rmw_rvalid", bus.rvalid, 2'b10);
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 14'h0200, 14'h0100, 8'h0, 8'h0);
    #1;
    chk("rmw_after_gnt", bus.gnt, 2'b01);
    chk("rmw_lock_err", lock_err, 1'b0);
    @(negedge clk);
    idle();

    // Forced release after HOLD_MAX idle cycles of ownership
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b01, 14'h0300, 14'h0400, 8'h0, 8'h0);
    #1;
    chk("hold_lock_gnt", bus.gnt, 2'b01);
    @(negedge clk);
    drive(2'b10, 2'b00, 2'b00, 14'h0300, 14'h0400, 8'h0, 8'h0);
    n = 0;
    le_early = 1'b0;
    while (n < 40) begin
      #1;
      if (bus.gnt != 2'b00) break;
      le_early = le_early | lock_err;
      n++;
      @(negedge clk);
    end
    chk("hold_wait_cycles", n, 16);
    chk("hold_gnt", bus.gnt, 2'b10);
    chk("hold_lock_err", lock_err, 1'b1);
    chk("hold_lock_err_early", le_early, 1'b0);
    @(negedge clk);
    idle();

    // Reset asserted while a read is on the memory bus
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 14'h0500, 14'h0, 8'h0, 8'h0);
    @(posedge clk);
    #1;
    chk("rr_strobe_before", res_rd, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rr_gnt", bus.gnt, 2'b00);
    chk("rr_bus", {res_wr, res_rd, res_addr, res_do}, 0);
    chk("rr_lock_err", lock_err, 1'b0);
    @(posedge clk);
    #1;
    chk("rr_rvalid", bus.rvalid, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rr_regrant", bus.gnt, 2'b01);
    @(negedge clk);
    idle();

    // Write then read of the same address, back to back
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b01, 2'b00, 14'h3FFF, 14'h0, 8'hFE, 8'h0);
    #1;
    chk("wr_gnt", bus.gnt, 2'b01);
    @(posedge clk);
    #1;
    chk("wr_strobe", {res_rd, res_wr}, 2'b01);
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 14'h3FFF, 14'h0, 8'h00, 8'h0);
    @(posedge clk);
    #1;
    idle();
    chk("wrrd_strobe", {res_rd, res_wr}, 2'b10);
    chk("wrrd_addr", res_addr, 14'h3FFF);
    @(posedge clk);
    #1;
    chk("wrrd_rvalid", bus.rvalid, 2'b01);
    chk("wrrd_rdata", bus.rdata, 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
